// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared types and default constants for the fetch-stage program counter.
//   - pc_state_e    : sequencer state (normal run, interrupt entry, in ISR)
//   - DEF_RESET_VEC : default PC after reset
//   - DEF_INT_VEC   : default interrupt entry PC
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_INT_ENTRY = 2'd1,
    ST_ISR       = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0020;
  localparam logic [31:0] DEF_INT_VEC   = 32'h0000_0000;

endpackage

// File: rtl/return_stack.sv
// return_stack
//   Circular hardware return-address stack with a top pointer and a count.
//   A push when full overwrites the oldest entry and sets a sticky overflow
//   flag; a pop when empty is ignored. Push has precedence if both are high
//   (the parent never asserts both).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, pop         : stack operations
//   push_data         : value written on push
//   top_data          : most recently pushed live entry (undefined when empty)
//   empty             : count == 0
//   overflow_sticky   : set when a push dropped an entry; cleared by reset
module return_stack #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            empty,
  output logic            overflow_sticky
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic [PTR_W-1:0] w_next_top;

  // With RAS_DEPTH a power of two, the pointer wraps naturally; when the
  // stack is full the slot after the top is the oldest entry.
  assign w_next_top = r_top + PTR_W'(1);

  // Storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[w_next_top] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (push) begin
      r_top <= w_next_top;
      if (r_count == FULL) begin
        r_overflow <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (pop && (r_count != '0)) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign top_data        = r_mem[r_top];
  assign empty           = (r_count == '0);
  assign overflow_sticky = r_overflow;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-stage program counter with a pending-interrupt latch, a two-step
//   interrupt entry (RUN -> INT_ENTRY -> ISR), a return-address stack for
//   call/ret/reti, and a memory-stage redirect that overrides stall.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   stall                        : hold PC
//   int_req                      : level interrupt request, latched as pending
//   mem_redirect, mem_target     : highest-priority redirect (beats stall)
//   branch_taken, branch_target  : branch/jump redirect
//   call                         : with branch_taken, push pc+STEP
//   ret, reti                    : pop RAS and jump (reti also leaves ISR)
//   ret_fallback                 : jump target when the RAS is empty
//   pc, pc_valid                 : fetch address and its validity
//   in_isr, int_pending          : interrupt status
//   ras_empty, ras_overflow      : RAS status
//   dbg_state                    : current sequencer state
//
// Handshake: there is no valid/ready pairing here; every input is sampled
// on each rising edge and all PC/state outputs are registered, so a change
// is visible one cycle after the edge that sampled the cause.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              STEP      = 1,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] INT_VEC   = PC_W'(DEF_INT_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            int_req,
  input  logic            mem_redirect,
  input  logic [PC_W-1:0] mem_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            call,
  input  logic            ret,
  input  logic            reti,
  input  logic [PC_W-1:0] ret_fallback,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            in_isr,
  output logic            int_pending,
  output logic            ras_empty,
  output logic            ras_overflow,
  output pc_state_e       dbg_state
);

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  pc_state_e       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_pc_valid;
  logic            r_in_isr;
  logic            r_pending;

  logic            w_take;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_push_data;
  logic [PC_W-1:0] w_top_data;
  logic            w_ras_empty;
  logic            w_ras_overflow;
  logic [PC_W-1:0] w_ret_target;

  // RAS side effects follow the same priority chain as the PC mux below so
  // that only the branch actually taken can push or pop.
  always_comb begin
    w_take      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = r_pc;
    if (!mem_redirect) begin
      if ((r_state == ST_RUN) && r_pending && !stall) begin
        w_take      = 1'b1;
        w_push      = 1'b1;
        w_push_data = r_pc;
      end else if ((r_state != ST_INT_ENTRY) && !stall) begin
        if (ret || reti) begin
          w_pop = 1'b1;
        end else if (branch_taken && call) begin
          w_push      = 1'b1;
          w_push_data = r_pc + STEP_V;
        end
      end
    end
  end

  assign w_ret_target = w_ras_empty ? ret_fallback : w_top_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b1;
      r_in_isr   <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      // A new request on the take cycle re-arms the latch.
      r_pending <= int_req | (r_pending & ~w_take);

      if (mem_redirect) begin
        // Cancels an in-flight entry; the interrupt stays pending.
        r_pc       <= mem_target;
        r_pc_valid <= 1'b1;
        if (r_state == ST_INT_ENTRY) begin
          r_state  <= ST_RUN;
          r_in_isr <= 1'b0;
        end
      end else if (w_take) begin
        r_state    <= ST_INT_ENTRY;
        r_pc_valid <= 1'b0;
      end else if (r_state == ST_INT_ENTRY) begin
        r_pc       <= INT_VEC;
        r_state    <= ST_ISR;
        r_in_isr   <= 1'b1;
        r_pc_valid <= 1'b1;
      end else if (stall) begin
        r_pc <= r_pc;
      end else if (reti && (r_state == ST_ISR)) begin
        r_pc     <= w_ret_target;
        r_state  <= ST_RUN;
        r_in_isr <= 1'b0;
      end else if (ret || reti) begin
        r_pc <= w_ret_target;
      end else if (branch_taken) begin
        r_pc <= branch_target;
      end else begin
        r_pc <= r_pc + STEP_V;
      end
    end
  end

  return_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk             (clk),
    .reset           (reset),
    .push            (w_push),
    .pop             (w_pop),
    .push_data       (w_push_data),
    .top_data        (w_top_data),
    .empty           (w_ras_empty),
    .overflow_sticky (w_ras_overflow)
  );

  assign pc           = r_pc;
  assign pc_valid     = r_pc_valid;
  assign in_isr       = r_in_isr;
  assign int_pending  = r_pending;
  assign ras_empty    = w_ras_empty;
  assign ras_overflow = w_ras_overflow;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Bench for pc_sequencer: a 32-bit instance for the main features and an
//   8-bit instance for address wrap-around. Expected PCs go into exp_q as
//   stimulus is driven and are popped after the sampling edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, int_req, mem_redirect, branch_taken, call, ret, reti;
  logic [31:0] mem_target, branch_target, ret_fallback;
  logic [31:0] pc;
  logic        pc_valid, in_isr, int_pending, ras_empty, ras_overflow;
  pc_state_e   dbg_state;

  logic        tie0 = 1'b0;
  logic [7:0]  tie8 = 8'h00;
  logic        m8_redirect;
  logic [7:0]  m8_target;
  logic [7:0]  pc8;
  logic        pc8_valid, in_isr8, pend8, empty8, ovf8;
  pc_state_e   state8;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] model_ras[$];

  pc_sequencer #(.PC_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .int_req(int_req),
    .mem_redirect(mem_redirect), .mem_target(mem_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .call(call), .ret(ret), .reti(reti), .ret_fallback(ret_fallback),
    .pc(pc), .pc_valid(pc_valid), .in_isr(in_isr), .int_pending(int_pending),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow), .dbg_state(dbg_state)
  );

  pc_sequencer #(.PC_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .stall(tie0), .int_req(tie0),
    .mem_redirect(m8_redirect), .mem_target(m8_target),
    .branch_taken(tie0), .branch_target(tie8),
    .call(tie0), .ret(tie0), .reti(tie0), .ret_fallback(tie8),
    .pc(pc8), .pc_valid(pc8_valid), .in_isr(in_isr8), .int_pending(pend8),
    .ras_empty(empty8), .ras_overflow(ovf8), .dbg_state(state8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; int_req = 0; mem_redirect = 0; branch_taken = 0;
    call = 0; ret = 0; reti = 0; m8_redirect = 0;
    mem_target = '0; branch_target = '0; ret_fallback = 32'h55; m8_target = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    n_total++;
    if (pc !== 32'h20) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h20); end
    n_total++;
    if ({pc_valid, in_isr, int_pending, ras_empty, ras_overflow} !== 5'b10010) begin
      n_bad++;
      $display("FAIL reset_flags got=%b exp=%b",
               {pc_valid, in_isr, int_pending, ras_empty, ras_overflow}, 5'b10010);
    end
    n_total++;
    if (dbg_state !== ST_RUN) begin n_bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_RUN); end
    reset = 0;
    exp_q.push_back(32'h21);
    exp_q.push_back(32'h22);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_total++;
      if (pc !== exp_v) begin n_bad++; $display("FAIL reset_seq pc=%h exp=%h", pc, exp_v); end
    end
  endtask

  task automatic test_redirect_stall();
    clear_inputs();
    stall = 1;
    exp_q.push_back(32'h22);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v) begin n_bad++; $display("FAIL stall_hold pc=%h exp=%h", pc, exp_v); end
    mem_redirect = 1; mem_target = 32'h100;
    exp_q.push_back(32'h100);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v) begin n_bad++; $display("FAIL redirect_over_stall pc=%h exp=%h", pc, exp_v); end
    mem_redirect = 0;
    exp_q.push_back(32'h100);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v) begin n_bad++; $display("FAIL stall_hold2 pc=%h exp=%h", pc, exp_v); end
    stall = 0;
    exp_q.push_back(32'h101);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v) begin n_bad++; $display("FAIL stall_release pc=%h exp=%h", pc, exp_v); end
  endtask

  task automatic test_call_ret();
    clear_inputs();
    mem_redirect = 1; mem_target = 32'h30;
    tick();
    clear_inputs();
    branch_taken = 1; call = 1; branch_target = 32'h80;
    exp_q.push_back(32'h80);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v || ras_empty !== 1'b0) begin
      n_bad++; $display("FAIL call pc=%h exp=%h ras_empty=%b exp=0", pc, exp_v, ras_empty);
    end
    clear_inputs();
    tick();
    ret = 1;
    exp_q.push_back(32'h31);
    tick();
    exp_v = exp_q.pop_front();
    n_total++;
    if (pc !== exp_v || ras_empty !== 1'b1) begin
      n_bad++; $display("FAIL ret pc=%h exp=%h ras_empty=%b exp=1", pc, exp_v, ras_empty);
    end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    clear_inputs();
    mem_redirect = 1; mem_target = 32'h40; int_req = 1;
    tick();
    n_total++;
    if (pc !== 32'h40 || int_pending !== 1'b1 || pc_valid !== 1'b1) begin
      n_bad++; $display("FAIL int_latch pc=%h pend=%b valid=%b exp 40/1/1", pc, int_pending, pc_valid);
    end
    clear_inputs();
    tick();
    n_total++;
    if (pc !== 32'h40 || pc_valid !== 1'b0 || dbg_state !== ST_INT_ENTRY || int_pending !== 1'b0) begin
      n_bad++;
      $display("FAIL int_take pc=%h valid=%b state=%0d pend=%b exp 40/0/1/0",
               pc, pc_valid, dbg_state, int_pending);
    end
    tick();
    n_total++;
    if (pc !== 32'h0 || in_isr !== 1'b1 || pc_valid !== 1'b1) begin
      n_bad++; $display("FAIL int_vector pc=%h isr=%b valid=%b exp 0/1/1", pc, in_isr, pc_valid);
    end
    int_req = 1;
    tick();
    int_req = 0;
    tick();
    n_total++;
    if (pc !== 32'h2 || int_pending !== 1'b1 || in_isr !== 1'b1) begin
      n_bad++; $display("FAIL isr_nested_req pc=%h pend=%b isr=%b exp 2/1/1", pc, int_pending, in_isr);
    end
    reti = 1;
    tick();
    reti = 0;
    n_total++;
    if (pc !== 32'h40 || in_isr !== 1'b0 || dbg_state !== ST_RUN || int_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL reti pc=%h isr=%b state=%0d pend=%b exp 40/0/0/1", pc, in_isr, dbg_state, int_pending);
    end
    tick();
    n_total++;
    if (pc !== 32'h40 || pc_valid !== 1'b0) begin
      n_bad++; $display("FAIL retake pc=%h valid=%b exp 40/0", pc, pc_valid);
    end
    // Stall is ignored during interrupt entry.
    stall = 1;
    tick();
    n_total++;
    if (pc !== 32'h0 || in_isr !== 1'b1) begin
      n_bad++; $display("FAIL entry_ignores_stall pc=%h isr=%b exp 0/1", pc, in_isr);
    end
    stall = 0; reti = 1;
    tick();
    n_total++;
    if (pc !== 32'h40 || in_isr !== 1'b0 || ras_empty !== 1'b1) begin
      n_bad++; $display("FAIL reti2 pc=%h isr=%b ras_empty=%b exp 40/0/1", pc, in_isr, ras_empty);
    end
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] cur;
    clear_inputs();
    mem_redirect = 1; mem_target = 32'h200;
    tick();
    clear_inputs();
    cur = 32'h200;
    model_ras.delete();
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1; call = 1; branch_target = 32'h300 + 32'(i) * 32'h10;
      model_ras.push_back(cur + 32'h1);
      if (model_ras.size() > 4) void'(model_ras.pop_front());
      exp_q.push_back(branch_target);
      cur = branch_target;
      tick();
      exp_v = exp_q.pop_front();
      n_total++;
      if (pc !== exp_v) begin n_bad++; $display("FAIL nested_call%0d pc=%h exp=%h", i, pc, exp_v); end
      n_total++;
      if (ras_overflow !== (i == 4)) begin
        n_bad++; $display("FAIL overflow_flag%0d got=%b exp=%b", i, ras_overflow, (i == 4));
      end
    end
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      ret = 1; ret_fallback = 32'h55;
      if (model_ras.size() == 0) exp_q.push_back(32'h55);
      else exp_q.push_back(model_ras.pop_back());
      tick();
      exp_v = exp_q.pop_front();
      n_total++;
      if (pc !== exp_v) begin n_bad++; $display("FAIL ret_lifo%0d pc=%h exp=%h", i, pc, exp_v); end
    end
    n_total++;
    if (ras_empty !== 1'b1 || ras_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ras_after_pops empty=%b ovf=%b exp 1/1", ras_empty, ras_overflow);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] mpc;
    clear_inputs();
    mem_redirect = 1; mem_target = 32'h1000;
    tick();
    clear_inputs();
    mpc = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      branch_target = $urandom;
      if (stall) mpc = mpc;
      else if (branch_taken) mpc = branch_target;
      else mpc = mpc + 32'h1;
      exp_q.push_back(mpc);
      tick();
      exp_v = exp_q.pop_front();
      n_total++;
      if (pc !== exp_v) begin n_bad++; $display("FAIL b2b%0d pc=%h exp=%h", i, pc, exp_v); end
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    clear_inputs();
    m8_redirect = 1; m8_target = 8'hFF;
    tick();
    n_total++;
    if (pc8 !== 8'hFF) begin n_bad++; $display("FAIL wrap_setup pc=%h exp=ff", pc8); end
    m8_redirect = 0;
    tick();
    n_total++;
    if (pc8 !== 8'h00) begin n_bad++; $display("FAIL wrap pc=%h exp=00", pc8); end
    tick();
    n_total++;
    if (pc8 !== 8'h01) begin n_bad++; $display("FAIL wrap_next pc=%h exp=01", pc8); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_redirect_stall();
    test_call_ret();
    test_interrupt();
    test_ras_overflow();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised next-generation program-counter unit for the fetch stage: it holds the fetch address and advances it by a configurable step. It adds four things to the basic counter:
- a pending-interrupt latch with a two-state interrupt entry sequence;
- a hardware return-address stack (RAS) for call/return and interrupt return;
- a memory-stage redirect that overrides stall;
- explicit fetch-valid and status outputs.

It sits between the hazard/branch logic and instruction memory.

## Interface
- PC_W, 32: PC and address width.
- STEP, 1: sequential increment, in words.
- RESET_VEC, 32'h20: PC after reset.
- INT_VEC, 32'h0: interrupt entry PC.
- RAS_DEPTH, 4: RAS entries, ≥2, power of two.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC, from the hazard unit.
- int_req  in  1  interrupt request, level; captured into the pending latch.
- mem_redirect  in  1  memory-stage redirect; overrides stall.
- mem_target  in  PC_W  target for mem_redirect.
- branch_taken  in  1  branch/jump redirect.
- branch_target  in  PC_W  target for branch_taken.
- call  in  1  push PC+STEP on the RAS; qualifies branch_taken.
- ret  in  1  pop the RAS and jump to the popped address.
- reti  in  1  return from interrupt; pop the RAS and leave ISR.
- ret_fallback  in  PC_W  target used when ret/reti finds the RAS empty.
- pc  out  PC_W  current fetch address.
- pc_valid  out  1  fetch at pc is architecturally valid.
- in_isr  out  1  high while the state is ISR.
- int_pending  out  1  pending latch.
- ras_empty  out  1  RAS count == 0.
- ras_overflow  out  1  sticky; set when a push drops an entry.

## Operation
- States: RUN, INT_ENTRY, ISR.
- Reset values: pc=RESET_VEC, state=RUN, pc_valid=1, int_pending=0, RAS count=0, ras_overflow=0.
- int_pending sets when int_req=1. It clears only on the cycle the interrupt is taken. A request arriving during ISR stays pending; there is no nesting.
- Per-cycle priority, highest first:
  1. reset
  2. mem_redirect: pc←mem_target. Applies in any state. Cancels INT_ENTRY back to RUN with the interrupt still pending.
  3. Interrupt take: state RUN, int_pending=1, stall=0. Push pc onto the RAS, go to INT_ENTRY, hold pc, pc_valid←0.
  4. INT_ENTRY: pc←INT_VEC, state←ISR, pc_valid←1. Unconditional; stall is ignored.
  5. stall=1: pc held.
  6. reti while in ISR: pc←pop, or ret_fallback if the RAS is empty; state←RUN. reti outside ISR is treated as ret.
  7. ret: pc←pop, or ret_fallback if the RAS is empty.
  8. branch_taken: pc←branch_target. If call=1, also push pc+STEP.
  9. Otherwise: pc←pc+STEP.
- Arithmetic: PC_W-bit, wraps modulo 2^PC_W. There is no overflow flag.
- RAS is circular with a top pointer and a count.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and sets ras_overflow.
  - Pop when empty leaves count at 0.
  - A push and a pop never both take effect in one cycle, because only one priority branch is taken.
- Lower-priority inputs asserted in the same cycle are ignored and not remembered. Only int_req is latched.

## Timing
- All outputs are registered; a change is visible one cycle after the sampling edge.
- Interrupt latency from int_req=1 with no stall: edge N latches pending, edge N+1 takes the interrupt (pc_valid=0), edge N+2 sets pc=INT_VEC. Fetch resumes at INT_VEC two cycles after pending is visible.
- Redirect, branch, ret and reti all take effect in one cycle.
- Reset asserted mid-INT_ENTRY or mid-ISR returns to the reset values on the next edge. Pending interrupts and RAS contents are discarded.

## Structure
- Package pc_seq_pkg holds:
  - the state enum {RUN, INT_ENTRY, ISR};
  - default constants for RESET_VEC and INT_VEC.
- Sub-module return_stack (parameters PC_W, RAS_DEPTH) provides:
  - inputs push, pop, push_data;
  - outputs top_data, empty, overflow_sticky.
- pc_sequencer contains the FSM, the priority mux and the pending latch.

## Test plan
- Reset: hold reset 2 cycles, release. pc=0x20, then 0x21, 0x22; pc_valid=1; ras_empty=1.
- Priority of redirect over stall: stall=1 and mem_redirect=1 with mem_target=0x100 → pc=0x100 next cycle. With stall=1 alone, pc holds.
- Interrupt round trip:
  - At pc=0x40, pulse int_req → in order: pending=1, pc_valid=0 with pc=0x40, then pc=0x0 with in_isr=1.
  - A second int_req during ISR keeps int_pending=1.
  - reti → pc=0x40, RUN, then the pending interrupt is taken again.
- Call/ret: call with target 0x80 at pc=0x30 → pc=0x80; ret → pc=0x31.
- RAS overflow, RAS_DEPTH=4:
  - Five nested calls → ras_overflow=1.
  - Five rets → the first four return the newest addresses in LIFO order. The fifth returns ret_fallback=0x55.
- Wrap: with PC_W=8, at pc=0xFF with no events → pc=0x00.
